// File: rtl/bnn_pkg.sv
// Shared constants and types for the neuron array and its configuration loader.
package bnn_pkg;

  localparam int NEURON_INPUTS    = 8;
  localparam int NEURON_BIAS_BITS = 3;
  localparam int NUM_NEURONS      = 8;
  localparam int CHAIN_BITS       = NUM_NEURONS * (NEURON_INPUTS + NEURON_BIAS_BITS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } loader_state_t;

  // Number of bits to take from the next byte: a full byte, or whatever is
  // left of the chain when fewer than eight bits remain.
  function automatic logic [3:0] bits_to_take(input logic [31:0] rem);
    if (rem >= 32'd8) begin
      return 4'd8;
    end
    return rem[3:0];
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// 8-bit parallel-in/serial-out register, MSB first, with a count of bits
// still to be shifted from the currently held byte.
module byte_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  input  logic [3:0] count_i,
  output logic       msb_o,
  output logic       last_o
);

  logic [7:0] sreg_q, sreg_d;
  logic [3:0] byte_left_q, byte_left_d;

  // Load a new byte, or shift left by one and count down the bits left.
  always_comb begin
    sreg_d      = sreg_q;
    byte_left_d = byte_left_q;
    if (load_i) begin
      sreg_d      = data_i;
      byte_left_d = count_i;
    end else if (shift_i) begin
      sreg_d = {sreg_q[6:0], 1'b0};
      if (byte_left_q != 4'd0) begin
        byte_left_d = byte_left_q - 4'd1;
      end
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q      <= 8'd0;
      byte_left_q <= 4'd0;
    end else begin
      sreg_q      <= sreg_d;
      byte_left_q <= byte_left_d;
    end
  end

  assign msb_o  = sreg_q[7];
  // Treat an empty counter as "last" too so the shift phase can never stall.
  assign last_o = (byte_left_q <= 4'd1);

endmodule

// File: rtl/param_loader.sv
// Streams host parameter bytes into the neuron setup/param_in shift chain,
// holding setup high for exactly CHAIN_BITS cycles per complete load.
module param_loader #(
  parameter int CHAIN_BITS = bnn_pkg::CHAIN_BITS,
  parameter int CNT_BITS   = $clog2(CHAIN_BITS + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       setup,
  output logic       param_out,
  output logic       busy,
  output logic       done
);

  import bnn_pkg::*;

  loader_state_t         state_q, state_d;
  logic [CNT_BITS-1:0]   remaining_q, remaining_d;
  logic                  ser_load;
  logic                  ser_shift;
  logic                  ser_msb;
  logic                  ser_last;
  logic [3:0]            take_count;

  assign take_count = bits_to_take(32'(remaining_q));

  byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .shift_i (ser_shift),
    .data_i  (in_data),
    .count_i (take_count),
    .msb_o   (ser_msb),
    .last_o  (ser_last)
  );

  // Next-state and remaining-bit counter; abort wins over every other event.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ser_load    = 1'b0;
    ser_shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WAIT_BYTE;
          remaining_d = CNT_BITS'(CHAIN_BITS);
        end
      end
      ST_WAIT_BYTE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          ser_shift = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_BITS'(1);
          end
          if (ser_last) begin
            state_d = (remaining_q <= CNT_BITS'(1)) ? ST_DONE : ST_WAIT_BYTE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset forces IDLE so setup drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // All outputs decode registered state only.
  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_WAIT_BYTE);
  assign setup     = (state_q == ST_SHIFT);
  assign param_out = setup & ser_msb;
  assign done      = (state_q == ST_DONE);

endmodule

// File: doc/param_loader.md
# param_loader

Upstream configuration stage for the neuron array. Accepts weight/bias bytes from the host over a valid/ready byte interface and serialises them into the daisy-chained `setup`/`param_in` shift path of the neurons. Asserts `setup` for exactly `CHAIN_BITS` clock cycles per load. Signals completion with a one-cycle `done` pulse.

## Interface

**Parameters**
- `CHAIN_BITS`, default 88: total bits in the neuron shift chain, e.g. 8 neurons × (8 weights + 3 bias). Must be ≥ 1.
- `CNT_BITS`, default `$clog2(CHAIN_BITS+1)`: width of the remaining-bit counter. Derived; not overridden.

**Ports**
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  level-sampled; begins a load when sampled high in IDLE.
- `abort`  in  1  cancels a load in progress.
- `in_data`  in  8  parameter byte; MSB is shifted out first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `setup`  out  1  drives every neuron's `setup`.
- `param_out`  out  1  drives `param_in` of the first neuron in the chain.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the full chain has been loaded.

## Operation

**States:** IDLE, WAIT_BYTE, SHIFT, DONE.

- **IDLE**
  - `in_ready`=0, `setup`=0.
  - `start`=1 → WAIT_BYTE; `remaining` ← `CHAIN_BITS`.
- **WAIT_BYTE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `sreg` ← `in_data`; `byte_left` ← min(8, `remaining`); → SHIFT.
  - `in_valid` low: hold indefinitely.
- **SHIFT**
  - `setup`=1, `param_out`=`sreg[7]`.
  - Each cycle: `sreg` ← `sreg<<1`, `byte_left`−1, `remaining`−1.
  - When `byte_left` reaches 1 on the current cycle: `remaining`==1 → DONE, else → WAIT_BYTE.
- **DONE**
  - `done`=1 for one cycle → IDLE.

**Rules**
- `setup` and `param_out` are decoded from registered state only; no combinational path from any input.
- Partial last byte: only its upper `CHAIN_BITS mod 8` bits are shifted; the low bits are discarded.
- Bit order: the first bit shifted ends at the far end of the chain. The host sends data for the last neuron first, each neuron's bias MSB first, weights MSB first.
- `abort`=1 in WAIT_BYTE/SHIFT/DONE → IDLE next edge.
  - No `done` pulse.
  - Chain contents are partial; the host must reload.
  - `abort` outranks `in_valid` and `start`.
- `start` while `busy` is ignored.
- `in_valid` outside WAIT_BYTE is ignored; the byte is not consumed (`in_ready`=0).
- `remaining` never underflows; it is width-checked against `CNT_BITS`.

**Reset values (all outputs):** state=IDLE, `in_ready`=0, `setup`=0, `param_out`=0, `busy`=0, `done`=0. `sreg`, `remaining` and `byte_left` clear to 0.
- Reset mid-SHIFT drops `setup` asynchronously, so no further chain shifts occur.

## Timing

- `start` sampled at edge 0 → WAIT_BYTE, `in_ready`=1 in cycle 1.
- Byte accepted at edge N → `setup`=1 for cycles N+1 … N+k, where k = bits taken from that byte (8, or the partial count).
- Back to WAIT_BYTE in cycle N+k+1. Minimum 9 cycles per full byte; no overlap of accept and shift.
- Zero-stall load with `CHAIN_BITS`=88:
  - Bytes accepted in cycles 1, 10, …, 91.
  - `setup` high for 88 cycles total.
  - `done` in cycle 100.
  - `busy` low and `start` honoured again from cycle 101.
- `setup` is never high for more than `CHAIN_BITS` cycles per load.

## Structure

- Shared package `bnn_pkg`:
  - `NEURON_INPUTS`(8), `NEURON_BIAS_BITS`(3), `NUM_NEURONS`.
  - `CHAIN_BITS` = `NUM_NEURONS`*(`NEURON_INPUTS`+`NEURON_BIAS_BITS`).
  - Loader state enum `loader_state_t`.
- One natural sub-module: `byte_serializer`, an 8-bit PISO holding `sreg` and `byte_left` with load/shift/empty. The FSM and `remaining` counter stay in `param_loader`.

## Test plan

- **Full load, `CHAIN_BITS`=88:** 11 bytes 0xA5 with `in_valid` always high. Expect `setup` high for exactly 88 cycles, `param_out` pattern 1010_0101 repeated, `done` at cycle 100. A behavioural 88-bit chain model holds 0xA5×11.
- **Partial byte, `CHAIN_BITS`=12:** bytes 0xFF then 0x9F. Expect 12 `setup` cycles and last four `param_out` bits = 1,0,0,1; `done` 1 cycle after the final shift.
- **Host stalls:** `in_valid` low 5 cycles before each byte. Expect `in_ready` held, `setup`=0 during the stalls, correct final chain contents, and `done` delayed by exactly 5×11 cycles.
- **Abort mid-SHIFT:** assert `abort` in the 3rd shift cycle of byte 4. Expect `setup`=0 the next cycle, no `done`, `busy`=0. A following `start` and full load then succeeds.
- **Async reset in SHIFT:** drop `rst_n` between edges. Expect `setup`, `busy` and `in_ready` low immediately; state IDLE after release.
- **Ignored events:** `start` pulsed while `busy`, and `in_valid` high during SHIFT. Expect no restart, no extra byte consumed, and a shift count of exactly `CHAIN_BITS`.
